// File: rtl/alu_issue_ctrl_if.sv
// Issue-side and ALU-side signal bundle for alu_issue_ctrl.
// slave  : the issue controller itself.
// master : the environment (instruction source, ALU, writeback observer).
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_operand1;
    logic [7:0]  alu_operand2;
    logic [2:0]  alu_operation;
    logic        alu_enable;
    logic [7:0]  alu_result;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        zero_flag;

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_operand1, alu_operand2, alu_operation,
               alu_enable, wb_valid, wb_addr, wb_data, zero_flag
    );

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_operand1, alu_operand2, alu_operation,
               alu_enable, wb_valid, wb_addr, wb_data, zero_flag
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller with a 4 x 8-bit register file.
// Instructions are NOP, LDI (load immediate) or ALU ops handed to an external
// ALU for one EXEC cycle, then written back in a one-cycle WB state.
// Optional feature: define ALU_ZERO_FLAG_EN to make zero_flag track whether
// the last written-back value was zero; otherwise zero_flag is tied low.
module alu_issue_ctrl (
    input  logic          clk,
    input  logic          rst,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;

    state_t      state_reg, state_next;
    logic [7:0]  regs_reg [4];
    logic [1:0]  rd_reg;
    logic [7:0]  op1_reg, op2_reg;
    logic [2:0]  op_reg;
    logic [1:0]  wb_addr_reg;
    logic [7:0]  wb_data_reg;

    logic        accept;
    logic        ready_c;
    logic        alu_enable_c;
    logic        wb_valid_c;

    logic [2:0]  f_op;
    logic [1:0]  f_rd, f_rs;
    logic [7:0]  f_imm;
    logic        instr_unused;

    assign f_op         = bus.instr[15:13];
    assign f_rd         = bus.instr[12:11];
    assign f_rs         = bus.instr[10:9];
    assign f_imm        = bus.instr[7:0];
    assign instr_unused = bus.instr[8];

    // Next-state decode and state-derived strobes.
    always_comb begin
        state_next   = state_reg;
        ready_c      = 1'b0;
        alu_enable_c = 1'b0;
        wb_valid_c   = 1'b0;
        accept       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c = 1'b1;
                accept  = bus.instr_valid;
                if (bus.instr_valid) begin
                    if (f_op == OP_LDI)
                        state_next = WB;
                    else if (f_op != OP_NOP)
                        state_next = EXEC;
                end
            end
            EXEC: begin
                alu_enable_c = 1'b1;
                state_next   = WB;
            end
            WB: begin
                wb_valid_c = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Operand/opcode capture at accept; writeback value capture on entry to WB
    // so wb_addr/wb_data only change when a new writeback is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_reg     <= 8'h00;
            op2_reg     <= 8'h00;
            op_reg      <= 3'b000;
            rd_reg      <= 2'd0;
            wb_addr_reg <= 2'd0;
            wb_data_reg <= 8'h00;
        end else begin
            if (accept && f_op != OP_NOP && f_op != OP_LDI) begin
                op1_reg <= regs_reg[f_rd];
                op2_reg <= regs_reg[f_rs];
                op_reg  <= f_op;
                rd_reg  <= f_rd;
            end
            if (accept && f_op == OP_LDI) begin
                wb_addr_reg <= f_rd;
                wb_data_reg <= f_imm;
            end
            if (state_reg == EXEC) begin
                wb_addr_reg <= rd_reg;
                wb_data_reg <= bus.alu_result;
            end
        end
    end

    // Register file: each entry commits on the WB->IDLE edge when addressed.
    for (genvar gi = 0; gi < 4; gi++) begin : g_regs
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                regs_reg[gi] <= 8'h00;
            else if (state_reg == WB && wb_addr_reg == 2'(gi))
                regs_reg[gi] <= wb_data_reg;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic zero_flag_reg;

    // Zero flag follows the committed writeback value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            zero_flag_reg <= 1'b0;
        else if (state_reg == WB)
            zero_flag_reg <= (wb_data_reg == 8'h00);
    end

    assign bus.zero_flag = zero_flag_reg;
`else
    assign bus.zero_flag = 1'b0;
`endif

    // Ready is masked by reset so it reads low while rst is held.
    assign bus.instr_ready   = ready_c & ~rst;
    assign bus.alu_enable    = alu_enable_c;
    assign bus.alu_operand1  = op1_reg;
    assign bus.alu_operand2  = op2_reg;
    assign bus.alu_operation = op_reg;
    assign bus.wb_valid      = wb_valid_c;
    assign bus.wb_addr       = wb_addr_reg;
    assign bus.wb_data       = wb_data_reg;
endmodule
